uart_mmio_ctrl: RTL and testbench
=================================

// Module: uart_mmio_ctrl
// PURPOSE
//  Memory-mapped UART controller on the CPU peripheral bus. Sequences a
//  TX serialiser and an RX deserialiser at a fixed baud rate and exposes
//  TXD/RXD/CON registers to the CPU. Raises irq on RX byte / TX done.
//  Sits beside the LED/switch/7-seg peripherals; rx/tx go to top-level pins.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency
//  BAUD     9600        line rate; BIT_CYC = CLK_HZ/BAUD (5208 at default)
//  BASE     32'h40000018  address of TXD; RXD = BASE+4, CON = BASE+8
// PORTS
//  clk     in   1   system clock, rising edge
//  reset   in   1   asynchronous, active-low reset
//  addr    in   32  bus byte address (word aligned)
//  rd_en   in   1   bus read strobe, one cycle
//  wr_en   in   1   bus write strobe, one cycle
//  wdata   in   32  write data
//  rdata   out  32  read data, combinational from addr (0 if unmapped)
//  rx      in   1   serial input, idle high, async to clk
//  tx      out  1   serial output, idle high
//  irq     out  1   level interrupt = CON[5] & (CON[1] | CON[2])
// BEHAVIOUR
//  Reset: tx=1, irq=0, both FSMs IDLE, CON=0, RXD=0, counters 0.
//   Reset mid-frame aborts: tx returns to 1 same time reset asserts.
//  rx passes a 2-flop synchroniser before use (2-cycle input latency).
//  Register map: TXD [7:0] W; RXD [7:0] R; CON R/W:
//   [0] tx_busy(R)  [1] tx_done(R, sticky)  [2] rx_valid(R)
//   [3] rx_overrun(R, sticky)  [4] frame_err(R, sticky)  [5] irq_en(R/W)
//  Reading RXD clears rx_valid. Reading CON clears bits 1,3,4 (W1C-free).
//  Writing CON updates only bit 5.
//  TX FSM IDLE->START->DATA->STOP->IDLE, each bit BIT_CYC cycles:
//   IDLE: write TXD with tx_busy=0 latches wdata[7:0], busy=1 next cycle.
//   START tx=0; DATA 8 bits LSB first; STOP tx=1; then tx_done=1, busy=0.
//   Frame = 10*BIT_CYC cycles from the cycle after the write.
//   Write TXD while busy: ignored, no state change.
//  RX FSM IDLE->START->DATA->STOP->IDLE:
//   IDLE: falling edge on synced rx -> START, count BIT_CYC/2.
//   START: at mid-bit rx=1 -> IDLE (glitch, no flag); rx=0 -> DATA.
//   DATA: sample at each BIT_CYC, shift LSB first, 8 samples -> STOP.
//   STOP: sample at BIT_CYC; rx=1 -> RXD<=byte, rx_valid=1 (if rx_valid
//    was already 1, rx_overrun=1, RXD overwritten); rx=0 -> frame_err=1,
//    RXD unchanged. Return to IDLE in the cycle after the stop sample.
//  Simultaneous: RXD read same cycle as new byte commit -> rx_valid stays
//   1, no overrun. CON read same cycle as tx_done/err set -> set wins.
//  TX and RX run fully independently (full duplex).
// TESTING
//  1 reset low mid-TX frame -> tx=1, CON=0, irq=0 while low; idle after.
//  2 write TXD=0x5A -> tx: 0,0,1,0,1,1,0,1,0,1 each 5208 cycles;
//    busy=1 during frame, tx_done=1 after; second write while busy ignored.
//  3 drive rx frame 0x49 at 9600 baud -> rx_valid=1, RXD read=0x49,
//    rx_valid=0 after read; irq=1 only when irq_en=1.
//  4 two frames 0x49,0x0C without reading -> RXD=0x0C, rx_overrun=1;
//    CON read returns bit3=1, next CON read bit3=0.
//  5 frame with stop bit 0 -> frame_err=1, rx_valid unchanged;
//    rx low pulse of 1000 cycles -> no flag, FSM back to IDLE.
//  6 RXD read on exact commit cycle of next byte -> rx_valid=1, no overrun.

Source files
------------

// File: rtl/uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl
//
// This is a memory-mapped UART for the CPU peripheral bus. It contains an
// 8N1 transmitter and an 8N1 receiver. Both run at BIT_CYC = CLK_HZ/BAUD
// clocks per bit.
//
// Register map (byte addresses):
//   BASE+0  TXD  [7:0] write-only. A write starts a frame when TX is idle.
//   BASE+4  RXD  [7:0] read-only. A read clears rx_valid.
//   BASE+8  CON  [0] tx_busy      [1] tx_done (sticky)
//                [2] rx_valid     [3] rx_overrun (sticky)
//                [4] frame_err (sticky)
//                [5] irq_en (the only writable bit)
//                Reading CON clears bits 1, 3 and 4.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   addr   bus byte address (word aligned)
//   rd_en  one-cycle read strobe
//   wr_en  one-cycle write strobe
//   wdata  write data
//   rdata  read data, combinational from addr (0 when unmapped)
//   rx     serial input, idle high, asynchronous to clk
//   tx     serial output, idle high
//   irq    level interrupt = irq_en & (tx_done | rx_valid)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_mmio_ctrl #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter logic [31:0] BASE   = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned   BIT_CYC   = CLK_HZ / BAUD;
  localparam int unsigned   CW        = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);
  localparam logic [31:0]   ADDR_TXD  = BASE;
  localparam logic [31:0]   ADDR_RXD  = BASE + 32'd4;
  localparam logic [31:0]   ADDR_CON  = BASE + 32'd8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Bus decode
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic unused_wdata;

  assign wr_txd = wr_en && (addr == ADDR_TXD);
  assign wr_con = wr_en && (addr == ADDR_CON);
  assign rd_rxd = rd_en && (addr == ADDR_RXD);
  assign rd_con = rd_en && (addr == ADDR_CON);
  assign unused_wdata = ^wdata[31:8];

  // Transmitter state
  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  logic          tx_done_set;
  logic          tx_busy;

  // Receiver state
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_commit, rx_ferr_set;

  // Status / register file
  logic [7:0] rxd_q, rxd_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       done_q, done_d;
  logic       irq_en_q, irq_en_d;

  assign tx_busy = (tx_state_q != S_IDLE);

  // TX FSM: a frame occupies exactly 10 bit periods, starting the cycle
  // after the accepted TXD write. tx is registered from the next state so
  // the pin never glitches on state decode.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_sh_d     = tx_sh_q;
    tx_done_set = 1'b0;
    unique case (tx_state_q)
      S_IDLE: begin
        if (wr_txd) begin
          tx_state_d = S_START;
          tx_sh_d    = wdata[7:0];
          tx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d  = S_IDLE;
          tx_cnt_d    = '0;
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    unique case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // RX FSM: the start bit is re-checked at mid-bit to reject glitches, and
  // every later sample lands one bit period after the previous one, i.e.
  // near the centre of each bit.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_commit   = 1'b0;
    rx_ferr_set = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = '0;
          if (rx_s2_q) rx_commit   = 1'b1;
          else         rx_ferr_set = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Status bits: a set event always beats a read-clear in the same cycle.
  // An RXD read coinciding with a commit consumes the old byte, so it is
  // not an overrun.
  always_comb begin
    rxd_d      = rx_commit ? rx_sh_q : rxd_q;
    rx_valid_d = rx_commit | (rx_valid_q & ~rd_rxd);
    ovr_d      = (rx_commit & rx_valid_q & ~rd_rxd) | (ovr_q & ~rd_con);
    ferr_d     = rx_ferr_set | (ferr_q & ~rd_con);
    done_d     = tx_done_set | (done_q & ~rd_con);
    irq_en_d   = wr_con ? wdata[5] : irq_en_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rxd_q      <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rxd_q      <= rxd_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      irq_en_q   <= irq_en_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == ADDR_RXD) begin
      rdata = {24'd0, rxd_q};
    end else if (addr == ADDR_CON) begin
      rdata = {26'd0, irq_en_q, ferr_q, ovr_q, rx_valid_q, done_q, tx_busy};
    end
  end

  assign tx  = tx_q;
  assign irq = irq_en_q & (done_q | rx_valid_q);

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
`timescale 1ns/1ps
module tb_uart_mmio_ctrl;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int B = 16;             // clocks per bit
  localparam int H = 8;              // half bit
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rx = 1'b1;
  logic        tx;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t pin_q[$];
  logic tx_exp_q[$];

  logic probe_en = 1'b0;
  logic tx_mon_en = 1'b0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  uart_mmio_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE(A_TXD)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  // All tasks are entered one time unit after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    exp_t x;
    x.name = nm; x.val = e;
    rd_q.push_back(x);
    addr = a; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic probe(input string nm, input logic etx, input logic eirq);
    exp_t x;
    x.name = nm; x.val = {30'd0, etx, eirq};
    pin_q.push_back(x);
    probe_en = 1'b1;
    @(posedge clk); #1;
    probe_en = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cyc(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(B);
    end
    rx = stop;
    wait_cyc(B);
    rx = 1'b1;
  endtask

  // Monitor: bus reads, pin probes and decoded TX serial bits.
  initial begin
    exp_t x;
    logic eb;
    logic mact;
    int   mcnt;
    int   mbit;
    mact = 1'b0; mcnt = 0; mbit = 0;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        n_chk++;
        if (rd_q.size() == 0) begin
          $display("FAIL rd_unexpected: rdata=%h with no expectation", rdata);
        end else begin
          x = rd_q.pop_front();
          if (rdata === x.val) n_pass++;
          else $display("FAIL %s: rdata=%h expected %h", x.name, rdata, x.val);
        end
      end
      if (probe_en) begin
        n_chk++;
        if (pin_q.size() == 0) begin
          $display("FAIL probe_unexpected: tx=%b irq=%b", tx, irq);
        end else begin
          x = pin_q.pop_front();
          if ({30'd0, tx, irq} === x.val) n_pass++;
          else $display("FAIL %s: tx=%b irq=%b expected tx=%b irq=%b",
                        x.name, tx, irq, x.val[1], x.val[0]);
        end
      end
      if (!reset || !tx_mon_en) begin
        mact = 1'b0;
      end else if (!mact) begin
        if (tx == 1'b0) begin
          mact = 1'b1; mcnt = 0; mbit = 0;
        end
      end else begin
        mcnt++;
        if (mcnt == H + mbit * B) begin
          n_chk++;
          if (tx_exp_q.size() == 0) begin
            $display("FAIL tx_extra_bit: tx=%b with no bit expected", tx);
          end else begin
            eb = tx_exp_q.pop_front();
            if (tx === eb) n_pass++;
            else $display("FAIL tx_bit%0d: tx=%b expected %b", mbit, tx, eb);
          end
          if (mbit == 9) mact = 1'b0;
          else mbit++;
        end
      end
      if (final_req && !final_done) begin
        n_chk++;
        if (rd_q.size() == 0 && pin_q.size() == 0 && tx_exp_q.size() == 0) n_pass++;
        else $display("FAIL leftover_expectations: rd=%0d pin=%0d txbits=%0d expected 0/0/0",
                      rd_q.size(), pin_q.size(), tx_exp_q.size());
        final_done = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] frame;
    // 1: reset state, then reset asserted in the middle of a TX frame
    wait_cyc(3);
    probe("t1_reset_pins", 1'b1, 1'b0);
    bus_rd("t1_reset_con", A_CON, 32'h0);
    reset = 1'b1;
    wait_cyc(2);
    bus_wr(A_CON, 32'h20);
    bus_wr(A_TXD, 32'h00);
    wait_cyc(30);
    reset = 1'b0;
    probe("t1_midframe_pins", 1'b1, 1'b0);
    bus_rd("t1_midframe_con", A_CON, 32'h0);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);
    probe("t1_after_pins", 1'b1, 1'b0);
    bus_rd("t1_after_con", A_CON, 32'h0);
    wait_cyc(200);
    bus_rd("t1_no_late_done", A_CON, 32'h0);

    // 2: transmit 0x5A, second write while busy is ignored
    frame = 10'b1_0101_1010_0;  // stop, data 0x5A, start (LSB sent first)
    for (int i = 0; i < 10; i++) tx_exp_q.push_back(frame[i]);
    tx_mon_en = 1'b1;
    bus_wr(A_TXD, 32'h5A);
    wait_cyc(20);
    bus_rd("t2_busy", A_CON, 32'h01);
    bus_wr(A_TXD, 32'hFF);
    bus_rd("t2_busy_after_ignored_wr", A_CON, 32'h01);
    wait_cyc(170);
    probe("t2_irq_masked", 1'b1, 1'b0);
    bus_rd("t2_done", A_CON, 32'h02);
    bus_rd("t2_done_cleared", A_CON, 32'h00);

    // 3: receive 0x49, irq gated by irq_en
    send_rx(8'h49, 1'b1);
    wait_cyc(4);
    probe("t3_irq_off", 1'b1, 1'b0);
    bus_rd("t3_con_valid", A_CON, 32'h04);
    bus_wr(A_CON, 32'h20);
    probe("t3_irq_on", 1'b1, 1'b1);
    bus_rd("t3_rxd", A_RXD, 32'h49);
    bus_rd("t3_con_after_read", A_CON, 32'h20);
    probe("t3_irq_cleared", 1'b1, 1'b0);
    bus_wr(A_CON, 32'h00);

    // 4: overrun
    send_rx(8'h49, 1'b1);
    send_rx(8'h0C, 1'b1);
    wait_cyc(4);
    bus_rd("t4_con_overrun", A_CON, 32'h0C);
    bus_rd("t4_con_overrun_cleared", A_CON, 32'h04);
    bus_rd("t4_rxd", A_RXD, 32'h0C);
    bus_rd("t4_con_empty", A_CON, 32'h00);

    // 5: framing error leaves valid byte alone; short glitch ignored
    send_rx(8'h33, 1'b1);
    send_rx(8'hA5, 1'b0);
    wait_cyc(4);
    bus_rd("t5_con_ferr", A_CON, 32'h14);
    bus_rd("t5_con_ferr_cleared", A_CON, 32'h04);
    bus_rd("t5_rxd_unchanged", A_RXD, 32'h33);
    bus_rd("t5_con_empty", A_CON, 32'h00);
    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(200);
    bus_rd("t5_glitch_no_flag", A_CON, 32'h00);
    send_rx(8'h5C, 1'b1);
    wait_cyc(4);
    bus_rd("t5_after_glitch_con", A_CON, 32'h04);
    bus_rd("t5_after_glitch_rxd", A_RXD, 32'h5C);

    // 6: RXD read on the exact commit cycle of the next byte
    send_rx(8'h11, 1'b1);
    wait_cyc(4);
    fork
      send_rx(8'h22, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        bus_rd("t6_rxd_at_commit", A_RXD, 32'h11);
      end
    join
    wait_cyc(4);
    bus_rd("t6_con_valid_no_ovr", A_CON, 32'h04);
    bus_rd("t6_rxd_new", A_RXD, 32'h22);
    bus_rd("t6_con_empty", A_CON, 32'h00);

    // Unmapped and write-only addresses read as zero
    bus_rd("map_txd_reads_zero", A_TXD, 32'h0);
    bus_rd("map_unmapped_zero", A_CON + 32'd4, 32'h0);

    wait_cyc(4);
    final_req = 1'b1;
    wait_cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
